// File: rtl/vga_reg_writer.sv
// Avalon-MM write master that replays queued (addr, data) commands into the VGA register file.
// Optional macro VBLANK_GATE_EN: hold batches until vblank and release them whole, ending at last=1.
module vga_reg_writer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_last,
    input  logic                     vblank,
    output logic                     av_chipselect,
    output logic                     av_write,
    output logic [ADDR_W-1:0]        av_address,
    output logic [DATA_W-1:0]        av_writedata,
    input  logic                     av_waitrequest,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef enum logic {IDLE, WRITE} state_t;

    ent_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q;
    state_t            state_q;
    logic              av_write_q;
    logic [ADDR_W-1:0] av_address_q;
    logic [DATA_W-1:0] av_writedata_q;
    logic              busy_q;

    ent_t head, nxt, cmd_ent, follow;
    logic push, accept, more, start, batch_end, write_nxt;

    assign cmd_ent   = '{last: cmd_last, addr: cmd_addr, data: cmd_data};
    assign head      = mem_q[rd_ptr_q];
    assign nxt       = mem_q[rd_ptr_q + AW'(1)];
    assign cmd_ready = ready_q && (level_q != LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign accept    = av_write_q && !av_waitrequest;
    assign level_d   = level_q + LW'(push) - LW'(accept);
    // With only the head left, a same-edge push is forwarded so back-to-back writes keep going.
    assign more      = (level_q > LW'(1)) || push;
    assign follow    = (level_q > LW'(1)) ? nxt : cmd_ent;

`ifdef VBLANK_GATE_EN
    logic [LW-1:0] pending_q;

    assign start     = vblank && (pending_q != '0);
    assign batch_end = head.last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_q + LW'(push && cmd_last) - LW'(accept && head.last);
    end
`else
    logic unused_ign;

    assign start      = (level_q != '0);
    assign batch_end  = 1'b0;
    assign unused_ign = ^{vblank, head.last, follow.last};
`endif

    always_comb begin
        write_nxt = 1'b0;
        if (state_q == IDLE) write_nxt = start;
        else                 write_nxt = !(accept && (batch_end || !more));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_ent;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (accept) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ready_q        <= 1'b0;
            av_write_q     <= 1'b0;
            av_address_q   <= '0;
            av_writedata_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            busy_q  <= (level_d != '0) || write_nxt;
            case (state_q)
                IDLE: if (start) begin
                    state_q        <= WRITE;
                    av_write_q     <= 1'b1;
                    av_address_q   <= head.addr;
                    av_writedata_q <= head.data;
                end
                WRITE: if (accept) begin
                    if (!write_nxt) begin
                        state_q    <= IDLE;
                        av_write_q <= 1'b0;
                    end else begin
                        av_address_q   <= follow.addr;
                        av_writedata_q <= follow.data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign av_write      = av_write_q;
    assign av_chipselect = av_write_q;
    assign av_address    = av_address_q;
    assign av_writedata  = av_writedata_q;
    assign level         = level_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_vga_reg_writer.sv
// Bench for vga_reg_writer: vector table, directed corner sequences and random traffic vs a queue model.
module tb_vga_reg_writer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid, cmd_ready, cmd_last, vblank;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              av_chipselect, av_write, av_waitrequest;
    logic [ADDR_W-1:0] av_address;
    logic [DATA_W-1:0] av_writedata;
    logic [LW-1:0]     level;
    logic              busy;

    vga_reg_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last), .vblank(vblank),
        .av_chipselect(av_chipselect), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; int wt; } vec_t;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 0;
    int  mlevel = 0;
    wr_t expq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: writes leave in push order; occupancy is pushes minus accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", 32'(level), 32'(mlevel));
            chk("cmd_ready", 32'(cmd_ready), 32'(mlevel != DEPTH));
            chk("busy", 32'(busy), 32'((mlevel != 0) || av_write));
            chk("chipselect", 32'(av_chipselect), 32'(av_write));
            if (av_write && !av_waitrequest) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_write: addr %0h data %0h with nothing queued", av_address, av_writedata);
                end else begin
                    wr_t w;
                    w = expq.pop_front();
                    chk("wr_addr", 32'(av_address), 32'(w.a));
                    chk("wr_data", 32'(av_writedata), 32'(w.d));
                end
                mlevel--;
            end
            if (cmd_valid && cmd_ready) begin
                expq.push_back('{cmd_addr, cmd_data});
                mlevel++;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_av(input int maxc, input string nm);
        int n = 0;
        while (!av_write && n < maxc) begin tick(); n++; end
        if (!av_write) begin
            checks++; errors++;
            $display("FAIL %s: av_write never rose within %0d cycles", nm, maxc);
        end
    endtask

    task automatic drain(input int maxc, input string nm);
        int n = 0;
        while ((level != 0 || av_write) && n < maxc) begin tick(); n++; end
        chk(nm, 32'(level != 0 || av_write), 32'd0);
    endtask

    task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic l);
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    vec_t vt [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{6'h04, 16'h0123, 0};
        vt[1] = '{6'h12, 16'hFFFF, 2};
        vt[2] = '{6'h00, 16'h0000, 1};
        vt[3] = '{6'h0A, 16'h8001, 3};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_last = 1'b1; vblank = 1'b1; av_waitrequest = 1'b0;
        repeat (2) tick();
        chk("rst_av_write", 32'(av_write), 0);
        chk("rst_cs", 32'(av_chipselect), 0);
        chk("rst_addr", 32'(av_address), 0);
        chk("rst_data", 32'(av_writedata), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 1);
        mon_en = 1;

        // Single-command latency and waitrequest hold, one vector at a time.
        for (int i = 0; i < 4; i++) begin
            av_waitrequest = (vt[i].wt != 0);
            push1(vt[i].a, vt[i].d, 1'b1);
            chk("vec_level1", 32'(level), 1);
            chk("vec_no_write_yet", 32'(av_write), 0);
            tick();
            chk("vec_write", 32'(av_write), 1);
            chk("vec_addr", 32'(av_address), 32'(vt[i].a));
            chk("vec_data", 32'(av_writedata), 32'(vt[i].d));
            for (int k = 0; k < vt[i].wt; k++) begin
                tick();
                chk("vec_hold_addr", 32'(av_address), 32'(vt[i].a));
                chk("vec_hold_data", 32'(av_writedata), 32'(vt[i].d));
            end
            av_waitrequest = 1'b0;
            tick();
            chk("vec_done_write", 32'(av_write), 0);
            chk("vec_done_level", 32'(level), 0);
        end

        // Backpressure: three queued, stable while stalled, then back-to-back.
        av_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = ADDR_W'(i + 1); cmd_data = DATA_W'(16'hA0 + i); cmd_last = (i == 2);
            tick();
        end
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("bp_write", 32'(av_write), 1);
        chk("bp_addr", 32'(av_address), 1);
        chk("bp_data", 32'(av_writedata), 32'hA0);
        av_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) begin
                chk("bp_nobubble", 32'(av_write), 1);
                chk("bp_next_addr", 32'(av_address), 32'(i + 2));
            end else begin
                chk("bp_end", 32'(av_write), 0);
            end
        end

        // Full FIFO and recovery.
        av_waitrequest = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cmd_valid = 1'b1; cmd_addr = ADDR_W'(i); cmd_data = DATA_W'(16'h100 + i); cmd_last = 1'b1;
            tick();
        end
        chk("full_ready", 32'(cmd_ready), 0);
        chk("full_level", 32'(level), DEPTH);
        cmd_addr = 6'h11; cmd_data = 16'h01FF;
        tick();
        chk("full_hold_level", 32'(level), DEPTH);
        av_waitrequest = 1'b0;
        tick();
        chk("full_ready_back", 32'(cmd_ready), 1);
        chk("full_level_dec", 32'(level), DEPTH - 1);
        tick();
        cmd_valid = 1'b0;
        chk("full_push_accept", 32'(level), DEPTH - 1);
        drain(100, "full_drain");
        chk("full_no_loss", 32'(expq.size()), 0);

`ifdef VBLANK_GATE_EN
        // Batch held until vblank; finishes even if vblank drops mid-batch.
        vblank = 1'b0;
        push1(6'h01, 16'h1111, 1'b0);
        push1(6'h02, 16'h2222, 1'b0);
        push1(6'h03, 16'h3333, 1'b1);
        repeat (4) begin tick(); chk("gate_hold", 32'(av_write), 0); end
        vblank = 1'b1;
        wait_av(4, "gate_start");
        tick();
        vblank = 1'b0;
        drain(20, "gate_complete");
        chk("gate_all_written", 32'(expq.size()), 0);
        // Incomplete batch waits for its last entry.
        vblank = 1'b1;
        push1(6'h05, 16'h5555, 1'b0);
        push1(6'h06, 16'h6666, 1'b0);
        repeat (5) begin tick(); chk("gate_incomplete", 32'(av_write), 0); end
        push1(6'h07, 16'h7777, 1'b1);
        drain(20, "gate_incomplete_done");
        chk("gate_incomplete_all", 32'(expq.size()), 0);
`endif

        // Reset during a write.
        av_waitrequest = 1'b1;
        push1(6'h08, 16'hDEAD, 1'b0);
        push1(6'h09, 16'hBEEF, 1'b0);
        push1(6'h0A, 16'hCAFE, 1'b1);
        wait_av(5, "rst_mid_start");
        mon_en = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_write", 32'(av_write), 0);
        chk("rst_mid_cs", 32'(av_chipselect), 0);
        chk("rst_mid_level", 32'(level), 0);
        expq.delete();
        mlevel = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        av_waitrequest = 1'b0;
        tick();
        mon_en = 1;
        repeat (6) begin tick(); chk("rst_no_stale", 32'(av_write), 0); end

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cmd_valid      = 1'($urandom_range(0, 1));
            cmd_addr       = ADDR_W'($urandom_range(0, 18));
            cmd_data       = DATA_W'($urandom);
            cmd_last       = ($urandom_range(0, 3) == 0) || (mlevel >= DEPTH - 2);
            vblank         = 1'($urandom_range(0, 1));
            av_waitrequest = ($urandom_range(0, 3) == 0);
            tick();
        end
        cmd_valid = 1'b0; av_waitrequest = 1'b0; vblank = 1'b1;
        begin
            int n = 0;
            while (!cmd_ready && n < 100) begin tick(); n++; end
        end
        push1(6'h12, 16'h0F0F, 1'b1);
        drain(200, "rand_drain");
        chk("rand_all_written", 32'(expq.size()), 0);

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
